// File: rtl/mul_hilo_ctrl.sv
// Operand/settle/capture sequencer around an external combinational 32x32 signed multiplier, with HI/LO result registers.
// Optional MUL_HILO_OVF_EN: registered flag, set when HI:LO does not fit in 32-bit signed.
module mul_hilo_ctrl #(
   parameter int unsigned SETTLE_CYCLES = 2   // legal 1..15
) (
   input  logic        clk,
   input  logic        clr_n,
   input  logic        start,
   input  logic [31:0] op_a,
   input  logic [31:0] op_b,
   input  logic        ack,
   output logic [31:0] mul_a,
   output logic [31:0] mul_b,
   input  logic [63:0] mul_p,
   input  logic        hi_ld,
   input  logic        lo_ld,
   input  logic [31:0] hi_in,
   input  logic [31:0] lo_in,
   output logic        busy,
   output logic        done,
   output logic [31:0] hi_out,
   output logic [31:0] lo_out,
   output logic        ovf
);

   localparam int unsigned CNT_W = 4;

   typedef enum logic [1:0] {S_IDLE, S_SETTLE, S_DONE} state_t;

   state_t             r_state;
   logic [CNT_W-1:0]   r_cnt;
   logic [31:0]        r_mul_a;
   logic [31:0]        r_mul_b;
   logic [31:0]        r_hi;
   logic [31:0]        r_lo;
   logic               r_busy;
   logic               r_done;

   logic               w_cap;
   logic               w_ld_ok;
   logic               w_hi_wr;
   logic               w_lo_wr;
   logic [31:0]        w_hi_nxt;
   logic [31:0]        w_lo_nxt;

   // Capture has priority; direct loads only outside SETTLE.
   assign w_cap    = (r_state == S_SETTLE) && (r_cnt == CNT_W'(1));
   assign w_ld_ok  = (r_state != S_SETTLE);
   assign w_hi_wr  = w_cap || (w_ld_ok && hi_ld);
   assign w_lo_wr  = w_cap || (w_ld_ok && lo_ld);
   assign w_hi_nxt = w_cap ? mul_p[63:32] : ((w_ld_ok && hi_ld) ? hi_in : r_hi);
   assign w_lo_nxt = w_cap ? mul_p[31:0]  : ((w_ld_ok && lo_ld) ? lo_in : r_lo);

   always_ff @(posedge clk or negedge clr_n) begin
      if (!clr_n) begin
         r_state <= S_IDLE;
         r_cnt   <= '0;
         r_mul_a <= '0;
         r_mul_b <= '0;
         r_hi    <= '0;
         r_lo    <= '0;
         r_busy  <= 1'b0;
         r_done  <= 1'b0;
      end else begin
         if (w_hi_wr) r_hi <= w_hi_nxt;
         if (w_lo_wr) r_lo <= w_lo_nxt;
         case (r_state)
            S_IDLE: begin
               if (start) begin
                  r_mul_a <= op_a;
                  r_mul_b <= op_b;
                  r_cnt   <= CNT_W'(SETTLE_CYCLES);
                  r_state <= S_SETTLE;
                  r_busy  <= 1'b1;
                  r_done  <= 1'b0;
               end
            end
            S_SETTLE: begin
               r_cnt <= r_cnt - CNT_W'(1);
               if (w_cap) begin
                  r_state <= S_DONE;
                  r_busy  <= 1'b0;
                  r_done  <= 1'b1;
               end
            end
            S_DONE: begin
               if (start) begin
                  r_mul_a <= op_a;
                  r_mul_b <= op_b;
                  r_cnt   <= CNT_W'(SETTLE_CYCLES);
                  r_state <= S_SETTLE;
                  r_busy  <= 1'b1;
                  r_done  <= 1'b0;
               end else if (ack) begin
                  r_state <= S_IDLE;
                  r_done  <= 1'b0;
               end
            end
            default: begin
               r_state <= S_IDLE;
               r_busy  <= 1'b0;
               r_done  <= 1'b0;
            end
         endcase
      end
   end

`ifdef MUL_HILO_OVF_EN
   logic r_ovf;

   // Evaluated on the values being written so the flag tracks HI:LO exactly.
   always_ff @(posedge clk or negedge clr_n) begin
      if (!clr_n) begin
         r_ovf <= 1'b0;
      end else if (w_hi_wr || w_lo_wr) begin
         r_ovf <= (w_hi_nxt != {32{w_lo_nxt[31]}});
      end
   end

   assign ovf = r_ovf;
`else
   assign ovf = 1'b0;
`endif

   assign mul_a  = r_mul_a;
   assign mul_b  = r_mul_b;
   assign busy   = r_busy;
   assign done   = r_done;
   assign hi_out = r_hi;
   assign lo_out = r_lo;

endmodule

// File: doc/mul_hilo_ctrl.md
# mul_hilo_ctrl

Sequencing and result stage wrapped around the combinational 32-bit Booth multiplier. It registers the operands that drive the multiplier and waits a fixed number of settle cycles for the deep combinational array. It then captures the 64-bit product into the CPU's HI/LO register pair and signals completion through a done/ack handshake. HI/LO are also directly loadable from the datapath bus.

## Interface
- SETTLE_CYCLES, 2, cycles allowed for multiplier propagation; legal range 1..15, 0 illegal
- clk  in  1  rising-edge clock
- clr_n  in  1  asynchronous active-low reset
- start  in  1  request a multiply of op_a × op_b
- op_a  in  32  multiplicand (signed)
- op_b  in  32  multiplier (signed)
- ack  in  1  consumer acknowledges result
- mul_a  out  32  registered operand driven to multiplier multiplicand
- mul_b  out  32  registered operand driven to multiplier multiplier
- mul_p  in  64  product from multiplier
- hi_ld  in  1  direct load HI from hi_in
- lo_ld  in  1  direct load LO from lo_in
- hi_in  in  32  HI load data
- lo_in  in  32  LO load data
- busy  out  1  multiply in progress
- done  out  1  result valid in HI/LO, held until ack or new start
- hi_out  out  32  HI register (product[63:32])
- lo_out  out  32  LO register (product[31:0])
- ovf  out  1  product does not fit in 32-bit signed (see Configuration)

## Operation
- States: IDLE, SETTLE, DONE. Counter is 4-bit.
- IDLE: busy=0, done=0.
  - start=1 at an edge: mul_a←op_a, mul_b←op_b, counter←SETTLE_CYCLES, go to SETTLE.
- SETTLE: busy=1, done=0.
  - Counter decrements each edge.
  - On the edge where the counter equals 1: HI←mul_p[63:32], LO←mul_p[31:0], go to DONE.
  - start, hi_ld and lo_ld are ignored.
- DONE: busy=0, done=1.
  - ack=1 → IDLE.
  - start=1 (with or without ack) → latch new operands and go to SETTLE. done falls; HI/LO keep the old result until the next capture.
- Direct loads are accepted only when busy=0, and only in IDLE or DONE. hi_ld and lo_ld are independent, and both may assert in the same cycle.
  - In DONE, a direct load with start in the same cycle: the load is applied and the new operation also starts.
- mul_a and mul_b hold their values from the start edge until the next accepted start.
- No arithmetic is performed here. The product is the multiplier's signed 64-bit result, captured bit-exact.

## Timing
- Reset (clr_n=0, asynchronous) forces:
  - state IDLE, counter 0
  - mul_a, mul_b, HI, LO = 0
  - busy=0, done=0, ovf=0
- Reset mid-SETTLE aborts the operation. No capture occurs and done does not assert.
- Latency: start sampled at edge E0; HI/LO updated and done=1 after edge E0+SETTLE_CYCLES. With the default, done is seen two cycles after start.
- Back-to-back operations: throughput is one result per SETTLE_CYCLES+1 cycles when start is asserted in DONE.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Configuration
- MUL_HILO_OVF_EN defined:
  - ovf is a register, recomputed on every HI or LO write (capture or direct load).
  - ovf = 1 iff HI ≠ {32{LO[31]}}.
  - Reset clears ovf to 0.
- MUL_HILO_OVF_EN undefined: the ovf port exists but is tied to 0, and no compare logic is present.

## Test plan
- Reset: drive clr_n low mid-simulation → hi_out=lo_out=0, busy=0, done=0, ovf=0 asynchronously, before the next clock edge.
- Basic multiply, op_a=7, op_b=0xFFFFFFFD, SETTLE_CYCLES=2:
  - busy=1 for 2 cycles, then done=1.
  - hi_out=0xFFFFFFFF, lo_out=0xFFFFFFEB, ovf=0.
- Overflow multiply, op_a=op_b=0x80000000:
  - hi_out=0x40000000, lo_out=0x00000000.
  - ovf=1 with MUL_HILO_OVF_EN defined, 0 without it.
- Ignored requests during SETTLE: pulse start with new operands and hi_ld with hi_in=0x12345678 → both ignored; the result equals the original operation and HI is not 0x12345678.
- Handshake in DONE:
  - ack → IDLE, done=0, HI/LO retained.
  - start without ack → done falls for SETTLE_CYCLES cycles, then the new product appears.
  - In IDLE, hi_ld with 0x00000001 → hi_out=1; with LO=0 and MUL_HILO_OVF_EN defined, ovf=1.
- Reset mid-SETTLE: assert clr_n low one cycle after start → done never asserts; HI/LO=0 after release.
